// File: rtl/dma_priority_arbiter.sv
// DMA DREQ priority resolver and HRQ/HLDA hold-request sequencer.
// Selects a channel using fixed or rotating priority, then grants it one-hot once the CPU acknowledges the hold.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] dreq_i,
    input  logic              dreq_pol,
    input  logic              dack_pol,
    input  logic              rot_pri,
    input  logic              ctrl_disable,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic              hlda,
    input  logic              eop,
    output logic              hrq,
    output logic              validDACK,
    output logic [NUM_CH-1:0] VALID_DREQ,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [NUM_CH-1:0] dack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] valid_dreq_nxt;
    logic [IDX_W-1:0]  prio_base;
    logic [IDX_W-1:0]  prio_base_nxt;
    logic [IDX_W-1:0]  search_base;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  grant_idx_nxt;
    logic [IDX_W-1:0]  rotate_base;
    logic              hrq_nxt;
    logic              valid_dack_nxt;

    // Software requests bypass the mask; the disable bit gates every source.
    assign eligible    = ctrl_disable ? '0 : ((dreq_q & ~mask) | sw_req);
    assign search_base = rot_pri ? prio_base : '0;
    assign rotate_base = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign dack        = dack_pol ? VALID_DREQ : ~VALID_DREQ;

    // Walk from the farthest offset down to the base so the closest requester wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(search_base) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (eligible[idx[IDX_W-1:0]]) begin
                winner = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        hrq_nxt        = hrq;
        valid_dack_nxt = validDACK;
        valid_dreq_nxt = VALID_DREQ;
        grant_idx_nxt  = grant_idx;
        prio_base_nxt  = rot_pri ? prio_base : '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_idx_nxt = winner;
                    hrq_nxt       = 1'b1;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                if (hlda) begin
                    valid_dreq_nxt = NUM_CH'(1) << grant_idx;
                    valid_dack_nxt = 1'b1;
                    state_nxt      = SERVICE;
                end else if (!eligible[grant_idx]) begin
                    hrq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                // An hlda drop coinciding with eop still counts as a completed service.
                if (eop || !hlda) begin
                    hrq_nxt        = 1'b0;
                    valid_dack_nxt = 1'b0;
                    valid_dreq_nxt = '0;
                    state_nxt      = IDLE;
                    if (eop && rot_pri) begin
                        prio_base_nxt = rotate_base;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            hrq        <= 1'b0;
            validDACK  <= 1'b0;
            VALID_DREQ <= '0;
            grant_idx  <= '0;
            prio_base  <= '0;
            dreq_q     <= '0;
        end else begin
            state      <= state_nxt;
            hrq        <= hrq_nxt;
            validDACK  <= valid_dack_nxt;
            VALID_DREQ <= valid_dreq_nxt;
            grant_idx  <= grant_idx_nxt;
            prio_base  <= prio_base_nxt;
            dreq_q     <= dreq_i ^ {NUM_CH{dreq_pol}};
        end
    end

endmodule
